// File: rtl/clk_en_gen.sv
// clk_en_gen -- lock-sequenced reset generator plus NUM_CH phase-accumulator
// clock-enable channels, all in the refclk domain.
//
// Ports
//   refclk    : the only clock
//   rst       : asynchronous active-high reset
//   locked    : PLL lock, asynchronous, synchronised internally
//   inc       : per-channel increment words, channel i at [i*ACC_W +: ACC_W]
//   inc_load  : one-cycle strobe capturing inc into the shadow registers
//   ch_en     : per-channel enable (0 freezes the accumulator)
//   sync_clr  : zero all accumulators together for phase alignment
//   ce        : one-cycle clock-enable pulses, f = f_refclk * inc / 2^ACC_W
//   rst_out   : registered active-high downstream reset, low only in RUN
//   running   : registered, high in RUN

// One accumulator channel: shadow increment, accumulator, registered carry.
module clk_en_gen_ch #(
    parameter int ACC_W = 32
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [ACC_W-1:0] inc_word,
    output logic             ce
);
    logic [ACC_W-1:0] inc_sh;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc_sh};

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            inc_sh <= '0;
            acc    <= '0;
            ce     <= 1'b0;
        end else begin
            // shadow loads in every state; the accumulator is untouched so
            // a rate change keeps the current phase
            if (load)
                inc_sh <= inc_word;
            if (!run || clr) begin
                acc <= '0;
                ce  <= 1'b0;
            end else if (!en) begin
                ce  <= 1'b0;
            end else begin
                acc <= sum[ACC_W-1:0];
                ce  <= sum[ACC_W];
            end
        end
    end
endmodule

module clk_en_gen #(
    parameter int NUM_CH   = 2,
    parameter int ACC_W    = 32,
    parameter int RST_HOLD = 16
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    locked,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    input  logic                    inc_load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    sync_clr,
    output logic [NUM_CH-1:0]       ce,
    output logic                    rst_out,
    output logic                    running
);
    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(RST_HOLD - 1);

    state_t      state;
    logic        lock_meta;
    logic        lock_s;
    logic [15:0] hold_cnt;
    logic        run_go;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
            rst_out  <= 1'b1;
            running  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_out <= 1'b1;
                    running <= 1'b0;
                    if (lock_s) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (hold_cnt == 16'd0) begin
                        state   <= RUN;
                        rst_out <= 1'b0;
                        running <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        rst_out <= 1'b1;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    rst_out <= 1'b1;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Qualify with lock_s so the channels stop on the same edge the FSM
    // leaves RUN, instead of one cycle later.
    assign run_go = (state == RUN) && lock_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_en_gen_ch #(.ACC_W(ACC_W)) u_ch (
            .refclk   (refclk),
            .rst      (rst),
            .run      (run_go),
            .clr      (sync_clr),
            .en       (ch_en[g]),
            .load     (inc_load),
            .inc_word (inc[g*ACC_W +: ACC_W]),
            .ce       (ce[g])
        );
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with NUM_CH=2, ACC_W=8, RST_HOLD=16.
// Inputs change and outputs are sampled on the falling edge of refclk.
// rc counts RUN cycles: rc=1 is the first sample with running high.
module tb_clk_en_gen;
    logic        refclk = 1'b0;
    logic        rst;
    logic        locked;
    logic [15:0] inc;
    logic        inc_load;
    logic [1:0]  ch_en;
    logic        sync_clr;
    logic [1:0]  ce;
    logic        rst_out;
    logic        running;

    int n_assert = 0;
    int n_fail   = 0;
    int rc       = 0;

    always #5 refclk = ~refclk;

    clk_en_gen #(.NUM_CH(2), .ACC_W(8), .RST_HOLD(16)) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (locked),
        .inc      (inc),
        .inc_load (inc_load),
        .ch_en    (ch_en),
        .sync_clr (sync_clr),
        .ce       (ce),
        .rst_out  (rst_out),
        .running  (running)
    );

    task automatic tick();
        @(negedge refclk);
        rc++;
    endtask

    // Counts samples until rst_out falls; checks outputs stay quiet meanwhile.
    task automatic wait_run(output int lat);
        bit done = 0;
        lat = 0;
        while (!done) begin
            @(negedge refclk);
            inc_load = 1'b0;
            lat++;
            if (!rst_out) begin
                done = 1;
            end else begin
                n_assert++;
                if (running !== 1'b0 || ce !== 2'b00) begin
                    n_fail++;
                    $display("FAIL pre_run_quiet lat=%0d: running=%b ce=%b want 0/00", lat, running, ce);
                end
                if (lat >= 200) begin
                    n_fail++;
                    $display("FAIL run_timeout: rst_out=%b after %0d cycles, want 0", rst_out, lat);
                    done = 1;
                end
            end
        end
        rc = 1;
    endtask

    task automatic bring_up(input logic [7:0] i0, input logic [7:0] i1, output int lat);
        rst = 1'b1; locked = 1'b1; inc = {i1, i0}; inc_load = 1'b0;
        ch_en = 2'b11; sync_clr = 1'b0;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        inc_load = 1'b1;
        wait_run(lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; locked = 1'b0; inc = 16'h8040; inc_load = 1'b1;
        ch_en = 2'b11; sync_clr = 1'b0;
        repeat (3) @(negedge refclk);
        n_assert++;
        if (rst_out !== 1'b1) begin n_fail++; $display("FAIL reset_rst_out: got %b want 1", rst_out); end
        n_assert++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
        n_assert++;
        if (ce !== 2'b00) begin n_fail++; $display("FAIL reset_ce: got %b want 00", ce); end
        inc_load = 1'b0;
        rst = 1'b0;
        // no lock: must sit in WAIT_LOCK
        for (int i = 0; i < 30; i++) begin
            @(negedge refclk);
            n_assert++;
            if (rst_out !== 1'b1 || running !== 1'b0 || ce !== 2'b00) begin
                n_fail++;
                $display("FAIL no_lock_idle cyc=%0d: rst_out=%b running=%b ce=%b want 1/0/00", i, rst_out, running, ce);
            end
        end
    endtask

    task automatic test_lockup();
        int lat;
        bring_up(8'h40, 8'h80, lat);
        n_assert++;
        if (lat !== 19) begin n_fail++; $display("FAIL lockup_latency: got %0d cycles want 19", lat); end
        n_assert++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL lockup_running: got %b want 1", running); end
    endtask

    task automatic test_rates();
        int lat;
        logic [1:0] exp_ce;
        bring_up(8'h40, 8'h80, lat);
        for (int k = 1; k <= 24; k++) begin
            if (k > 1) tick();
            exp_ce[0] = (k >= 5) && ((k - 5) % 4 == 0);
            exp_ce[1] = (k >= 3) && ((k - 3) % 2 == 0);
            n_assert++;
            if (ce !== exp_ce) begin
                n_fail++;
                $display("FAIL rates rc=%0d: ce=%b want %b", k, ce, exp_ce);
            end
        end
    endtask

    task automatic test_fractional();
        int lat;
        int hist [1:80];
        int pos [$];
        int sum;
        int pat [3] = '{3, 2, 3};
        bring_up(8'h60, 8'h00, lat);
        for (int k = 1; k <= 80; k++) begin
            if (k > 1) tick();
            hist[k] = int'(ce[0]);
            if (ce[0]) pos.push_back(k);
        end
        n_assert++;
        if (pos.size() == 0 || pos[0] != 4) begin
            n_fail++;
            $display("FAIL frac_first: first pulse rc=%0d want 4", pos.size() ? pos[0] : -1);
        end
        for (int w = 2; w <= 73; w++) begin
            sum = 0;
            for (int j = 0; j < 8; j++) sum += hist[w + j];
            n_assert++;
            if (sum != 3) begin n_fail++; $display("FAIL frac_window start=%0d: %0d pulses want 3", w, sum); end
        end
        for (int j = 0; j + 1 < pos.size(); j++) begin
            n_assert++;
            if (pos[j+1] - pos[j] != pat[j % 3]) begin
                n_fail++;
                $display("FAIL frac_period idx=%0d: got %0d want %0d", j, pos[j+1] - pos[j], pat[j % 3]);
            end
        end
    endtask

    task automatic test_lock_loss();
        int lat;
        bring_up(8'h40, 8'h80, lat);
        repeat (5) tick();
        locked = 1'b0;
        repeat (3) tick();
        n_assert++;
        if (rst_out !== 1'b1 || running !== 1'b0 || ce !== 2'b00) begin
            n_fail++;
            $display("FAIL lock_loss_3cyc: rst_out=%b running=%b ce=%b want 1/0/00", rst_out, running, ce);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_assert++;
            if (rst_out !== 1'b1 || ce !== 2'b00) begin
                n_fail++;
                $display("FAIL lock_loss_hold cyc=%0d: rst_out=%b ce=%b want 1/00", i, rst_out, ce);
            end
        end
        locked = 1'b1;
        wait_run(lat);
        n_assert++;
        if (lat !== 19) begin n_fail++; $display("FAIL relock_latency: got %0d cycles want 19", lat); end
        for (int k = 2; k <= 5; k++) begin
            tick();
            n_assert++;
            if (ce[0] !== (k == 5)) begin
                n_fail++;
                $display("FAIL relock_phase rc=%0d: ce0=%b want %b", k, ce[0], (k == 5));
            end
        end
    endtask

    task automatic test_async_reset();
        int lat;
        bring_up(8'h40, 8'h80, lat);
        repeat (4) tick();
        @(posedge refclk);
        #3 rst = 1'b1;
        #1;
        n_assert++;
        if (rst_out !== 1'b1 || running !== 1'b0 || ce !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: rst_out=%b running=%b ce=%b want 1/0/00", rst_out, running, ce);
        end
        @(negedge refclk);
        rst = 1'b0;
        wait_run(lat);
        n_assert++;
        if (lat !== 19) begin n_fail++; $display("FAIL rerun_latency: got %0d cycles want 19", lat); end
    endtask

    task automatic test_controls();
        int lat;
        int c0;
        logic [1:0] tbl [12] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00,
                                 2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01};
        bring_up(8'h60, 8'h80, lat);
        repeat (5) tick();          // rc=6; both channels overflow on the next edge
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        for (int k = 7; k <= 18; k++) begin
            if (k > 7) tick();
            n_assert++;
            if (ce !== tbl[k-7]) begin
                n_fail++;
                $display("FAIL sync_clr rc=%0d: ce=%b want %b", k, ce, tbl[k-7]);
            end
        end
        ch_en = 2'b10;
        for (int k = 19; k <= 34; k++) begin
            tick();
            n_assert++;
            if (ce !== {1'(k % 2), 1'b0}) begin
                n_fail++;
                $display("FAIL ch_en_off rc=%0d: ce=%b want %b", k, ce, {1'(k % 2), 1'b0});
            end
        end
        ch_en = 2'b11;
        c0 = 0;
        repeat (8) begin tick(); c0 += int'(ce[0]); end
        n_assert++;
        if (c0 != 3) begin n_fail++; $display("FAIL ch_en_resume: %0d pulses want 3", c0); end
    endtask

    task automatic test_boundaries();
        int lat;
        int c0, c1;
        bring_up(8'h00, 8'h80, lat);
        c0 = 0; c1 = 0;
        for (int k = 2; k <= 1001; k++) begin
            tick();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
        end
        n_assert++;
        if (c0 != 0) begin n_fail++; $display("FAIL inc_zero: %0d pulses want 0", c0); end
        n_assert++;
        if (c1 != 500) begin n_fail++; $display("FAIL half_rate: %0d pulses want 500", c1); end
        inc = 16'h80FF;
        inc_load = 1'b1;
        tick();
        inc_load = 1'b0;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
        end
        n_assert++;
        if (c0 != 255) begin n_fail++; $display("FAIL inc_ff: %0d pulses in 256 want 255", c0); end
        n_assert++;
        if (c1 != 128) begin n_fail++; $display("FAIL live_load_ch1: %0d pulses in 256 want 128", c1); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lockup();
        test_rates();
        test_fractional();
        test_lock_loss();
        test_async_reset();
        test_controls();
        test_boundaries();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
- REQ-001 SHALL provide parameter NUM_CH, default 2: number of clock-enable channels, legal range 1..8.
- REQ-002 SHALL provide parameter ACC_W, default 32: phase-accumulator width per channel, legal range 8..32.
- REQ-003 SHALL provide parameter RST_HOLD, default 16: refclk cycles for which rst_out is held after lock, legal range 1..65535.
- REQ-004 SHALL provide port refclk, input, 1 bit: the single clock; all logic is in this domain.
- REQ-005 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-006 SHALL provide port locked, input, 1 bit: PLL lock indication, asynchronous to refclk.
- REQ-007 SHALL provide port inc, input, NUM_CH*ACC_W bits: channel i increment word in bits [i*ACC_W +: ACC_W].
- REQ-008 SHALL provide port inc_load, input, 1 bit: single-cycle strobe that captures inc.
- REQ-009 SHALL provide port ch_en, input, NUM_CH bits: per-channel enable.
- REQ-010 SHALL provide port sync_clr, input, 1 bit: clears all accumulators together (phase alignment).
- REQ-011 SHALL provide port ce, output, NUM_CH bits: one-cycle clock-enable pulses.
- REQ-012 SHALL provide port rst_out, output, 1 bit: synchronous, active-high downstream reset.
- REQ-013 SHALL provide port running, output, 1 bit: high in the RUN state.

Function
- REQ-014 SHALL synchronise locked through 2 refclk flops to form lock_s; all decisions SHALL use lock_s only.
- REQ-015 SHALL implement FSM states WAIT_LOCK, HOLD and RUN.
- REQ-016 WAIT_LOCK SHALL move to HOLD when lock_s=1, loading hold counter = RST_HOLD-1.
- REQ-017 HOLD SHALL decrement the counter each cycle and move to RUN on the cycle the counter equals 0.
- REQ-018 HOLD and RUN SHALL return to WAIT_LOCK on the first cycle lock_s=0.
- REQ-019 rst_out SHALL be registered, asserted (=1) in all states except RUN, and deasserted starting the first RUN cycle.
- REQ-020 running SHALL equal (state==RUN), registered.
- REQ-021 SHALL hold per-channel shadow increment registers, loaded from inc on cycles where inc_load=1, in any state.
- REQ-022 In RUN with ch_en[i]=1, acc_i SHALL add inc_i each cycle, modulo 2^ACC_W.
- REQ-023 ce[i] SHALL be a registered copy of the add carry-out, so ce[i]=1 exactly in the cycle after an overflow; output frequency = f_refclk*inc_i/2^ACC_W.
- REQ-024 An inc_load SHALL NOT clear the accumulators; the new increment SHALL be used from the cycle after the strobe.
- REQ-025 ch_en[i]=0 SHALL freeze acc_i and force ce[i]=0 the next cycle.
- REQ-026 sync_clr=1 SHALL set all accumulators to 0 and force ce=0 the next cycle.
- REQ-027 When sync_clr=1 coincides with an add, sync_clr SHALL take priority.
- REQ-028 Outside RUN, all accumulators SHALL be held at 0 and ce SHALL be 0.
- REQ-029 inc_i=0 SHALL produce no pulses.
- REQ-030 inc_i=2^(ACC_W-1) SHALL produce a pulse every 2nd cycle.

Reset
- REQ-031 rst=1 SHALL asynchronously force: state WAIT_LOCK, synchroniser flops 0, hold counter 0, all accumulators 0, all shadow increments 0, ce=0, running=0, rst_out=1.
- REQ-032 Deassertion of rst mid-operation SHALL restart the lock sequence from WAIT_LOCK; no output glitch to rst_out=0 is permitted.

Verification
- REQ-033 SHALL test lock-up: locked=1 from reset, RST_HOLD=16 -> rst_out falls and running rises exactly 2+1+16 cycles after rst release (2 sync + 1 WAIT_LOCK + 16 HOLD), ±0 cycles.
- REQ-034 SHALL test rates: ACC_W=8, inc0=0x40, inc1=0x80 -> ce[0] every 4 cycles and ce[1] every 2 cycles, first ce[0] on RUN cycle 5.
- REQ-035 SHALL test a fractional rate: ACC_W=8, inc0=0x60 -> exactly 3 pulses in every 8-cycle window, period pattern 3,3,2.
- REQ-036 SHALL test lock loss: drop locked during RUN -> rst_out=1 and ce=0 within 3 cycles; after relock, re-run the full HOLD count.
- REQ-037 SHALL test controls: sync_clr in the same cycle as an overflow -> no pulse, accumulators 0; ch_en[0]=0 -> ce[0] stays 0 while ce[1] is unaffected.
- REQ-038 SHALL test boundaries: inc0=0 -> no pulses over 1000 cycles; inc0=0xFF (ACC_W=8) -> 255 pulses per 256 cycles.
